// File: rtl/serial_adder_ctrl.sv
// Bit-serial add sequencer around an external combinational full adder; o_err under SERIAL_ADDER_CHECK_EN.
// Latency: start accepted on edge N, o_done pulses in the cycle after edge N+WIDTH (one add per WIDTH+1 cycles).
// Backpressure: none; i_start is only sampled outside RUN and is otherwise dropped, never queued.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic             o_fa_bit1,
    output logic             o_fa_bit2,
    output logic             o_fa_carry,
    input  logic             i_fa_sum,
    input  logic             i_fa_carry,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
`ifdef SERIAL_ADDER_CHECK_EN
    ,
    output logic             o_err
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_shift_sum;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    logic             w_accept;
    logic             w_run;
    logic             w_last;
    logic [WIDTH-1:0] w_sum_shifted;

    assign w_run         = (r_state == S_RUN);
    assign w_accept      = i_start && !w_run;
    assign w_last        = w_run && (r_cnt == LAST_BIT);
    assign w_sum_shifted = {i_fa_sum, r_shift_sum[WIDTH-1:1]};

    // Adder inputs come from registers only, so there is no loop through the external full adder.
    assign o_fa_bit1  = r_a[0];
    assign o_fa_bit2  = r_b[0];
    assign o_fa_carry = r_carry;

    assign o_busy = w_run;
    assign o_done = (r_state == S_DONE);
    assign o_sum  = r_sum;
    assign o_cout = r_cout;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_next_state = S_RUN;
            S_RUN:   if (w_last)  w_next_state = S_DONE;
            S_DONE:  w_next_state = i_start ? S_RUN : S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_a         <= '0;
            r_b         <= '0;
            r_carry     <= 1'b0;
            r_cnt       <= '0;
            r_shift_sum <= '0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
        end else if (w_accept) begin
            r_a     <= i_a;
            r_b     <= i_b;
            r_carry <= i_cin;
            r_cnt   <= '0;
        end else if (w_run) begin
            // Operand bits leave at the LSB while sum bits enter at the MSB, so after WIDTH shifts bit 0 lands in place.
            r_a         <= r_a >> 1;
            r_b         <= r_b >> 1;
            r_carry     <= i_fa_carry;
            r_cnt       <= r_cnt + CNT_ONE;
            r_shift_sum <= w_sum_shifted;
            if (w_last) begin
                r_sum  <= w_sum_shifted;
                r_cout <= i_fa_carry;
            end
        end
    end

`ifdef SERIAL_ADDER_CHECK_EN
    logic [WIDTH:0] r_ref;
    logic           r_err;

    assign o_err = r_err;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ref <= '0;
            r_err <= 1'b0;
        end else begin
            if (w_accept) begin
                r_ref <= {1'b0, i_a} + {1'b0, i_b} + {{WIDTH{1'b0}}, i_cin};
            end
            // Compared in DONE, where the reference still belongs to the add just finished.
            if (r_state == S_DONE) begin
                r_err <= ({r_cout, r_sum} != r_ref);
            end
        end
    end
`endif

endmodule
